// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared constants for the compare-timer interrupt controller: register word
// addresses, CTRL / STATUS bit positions and the controller state encoding.
// ----------------------------------------------------------------------------
package timer_pkg;

    // Register word addresses (value on the A select lines)
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CMP    = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IE       = 2;

    // STATUS bit positions (state occupies bits 3:2)
    localparam int STAT_PEND = 0;
    localparam int STAT_OVR  = 1;

    // Controller state, readable through STATUS[3:2]
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

endpackage : timer_pkg

// File: rtl/timer_irq_ctrl_if.sv
// ----------------------------------------------------------------------------
// timer_irq_ctrl_if
// Simple register bus between a core (master) and the timer interrupt
// controller (slave).
//   A  : register word select (CTRL / CMP / PERIOD / STATUS)
//   WD : write data
//   WE : write strobe for the register selected by A
//   RD : combinational read data of the register selected by A
// ----------------------------------------------------------------------------
interface timer_irq_ctrl_if;

    logic [1:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;

    modport master (output A, output WD, output WE, input  RD);
    modport slave  (input  A, input  WD, input  WE, output RD);

endinterface : timer_irq_ctrl_if

// File: rtl/timer_cmp_match.sv
// ----------------------------------------------------------------------------
// timer_cmp_match
// Detects a compare match once per timer step: the timer must equal the
// compare value AND differ from its value sampled on the previous clock, so
// a prescaled timer that holds a value for many cycles yields one match.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_timer    : current free-running timer count
//   i_cmp      : compare value
//   o_match    : combinational match indication for this cycle
// ----------------------------------------------------------------------------
module timer_cmp_match (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_timer,
    input  logic [31:0] i_cmp,
    output logic        o_match
);

    logic [31:0] r_prev;

    // Reset value 0 means the first sample after reset only matches when it
    // is non-zero and equal to the compare value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else begin
            // NOTE: non-blocking assignment for all clocked state so every
            // register samples pre-edge values regardless of block ordering.
            r_prev <= i_timer;
        end
    end

    assign o_match = (i_timer == i_cmp) && (i_timer != r_prev);

endmodule : timer_cmp_match

// File: rtl/timer_irq_ctrl.sv
// ----------------------------------------------------------------------------
// timer_irq_ctrl
// Compare-timer interrupt controller. Watches an external free-running timer,
// raises PEND on a compare match while ARMED, optionally reloads CMP by
// PERIOD (periodic mode) and drives a registered level interrupt.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : register bus slave (A, WD, WE in; RD out)
//   timer_val  : current count of the free-running timer peripheral
//   irq        : registered PEND & IE
// Registers: CTRL{IE,PERIODIC,EN}, CMP, PERIOD, STATUS{state,OVR,PEND}
// ----------------------------------------------------------------------------
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter logic [31:0] RESET_CMP = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    timer_irq_ctrl_if.slave   bus,
    input  logic [31:0]       timer_val,
    output logic              irq
);

    logic [2:0]  r_ctrl;
    logic [31:0] r_cmp;
    logic [31:0] r_period;
    logic        r_pend;
    logic        r_ovr;
    logic        r_irq;
    state_e      r_state;
    state_e      w_state_nxt;

    logic w_wr_ctrl;
    logic w_wr_cmp;
    logic w_wr_period;
    logic w_wr_status;
    logic w_match_raw;
    logic w_armed;
    logic w_hit;

    assign w_wr_ctrl   = bus.WE && (bus.A == ADDR_CTRL);
    assign w_wr_cmp    = bus.WE && (bus.A == ADDR_CMP);
    assign w_wr_period = bus.WE && (bus.A == ADDR_PERIOD);
    assign w_wr_status = bus.WE && (bus.A == ADDR_STATUS);

    timer_cmp_match u_match (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_timer (timer_val),
        .i_cmp   (r_cmp),
        .o_match (w_match_raw)
    );

    // A match only counts while ARMED, and a simultaneous CMP write wins.
    assign w_hit = w_match_raw && w_armed && !w_wr_cmp;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        if (w_wr_ctrl && !bus.WD[CTRL_EN]) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_ctrl[CTRL_EN]) w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_hit && !r_ctrl[CTRL_PERIODIC]) w_state_nxt = ST_EXPIRED;
                end
                ST_EXPIRED: begin
                    if (w_wr_cmp && r_ctrl[CTRL_EN]) w_state_nxt = ST_ARMED;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_armed = 1'b0;
        case (r_state)
            ST_ARMED: w_armed = 1'b1;
            default:  w_armed = 1'b0;
        endcase
    end

    // ---------------- Registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl   <= '0;
            r_cmp    <= RESET_CMP;
            r_period <= '0;
            r_pend   <= 1'b0;
            r_ovr    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl)   r_ctrl   <= bus.WD[2:0];
            if (w_wr_period) r_period <= bus.WD;

            if (w_wr_cmp) begin
                r_cmp <= bus.WD;
            end else if (w_hit && r_ctrl[CTRL_PERIODIC]) begin
                r_cmp <= r_cmp + r_period;
            end

            // Set wins over write-1-clear.
            if (w_hit) begin
                r_pend <= 1'b1;
            end else if (w_wr_status && bus.WD[STAT_PEND]) begin
                r_pend <= 1'b0;
            end

            if (w_hit && r_pend) begin
                r_ovr <= 1'b1;
            end else if (w_wr_status && bus.WD[STAT_OVR]) begin
                r_ovr <= 1'b0;
            end

            r_irq <= r_pend && r_ctrl[CTRL_IE];
        end
    end

    assign irq = r_irq;

    // ---------------- Read mux ----------------
    always_comb begin
        bus.RD = '0;
        case (bus.A)
            ADDR_CTRL:   bus.RD = {29'd0, r_ctrl};
            ADDR_CMP:    bus.RD = r_cmp;
            ADDR_PERIOD: bus.RD = r_period;
            ADDR_STATUS: bus.RD = {28'd0, r_state, r_ovr, r_pend};
            default:     bus.RD = '0;
        endcase
    end

endmodule : timer_irq_ctrl

// File: tb/tb_timer_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_timer_irq_ctrl
// Scenario-based bench for timer_irq_ctrl. Expected values are pushed to a
// queue when the stimulus is applied and popped when the DUT result is read.
// ----------------------------------------------------------------------------
module tb_timer_irq_ctrl;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] timer_val;
    logic        irq;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] e;

    timer_irq_ctrl_if bus ();

    timer_irq_ctrl #(.RESET_CMP(32'hFFFF_FFFF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .timer_val (timer_val),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.A  = a;
        bus.WD = d;
        bus.WE = 1'b1;
        tick();
        bus.WE = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.A = a;
        #1;
        d = bus.RD;
    endtask

    task automatic do_reset();
        bus.WE    = 1'b0;
        bus.A     = ADDR_CTRL;
        bus.WD    = '0;
        timer_val = '0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        rd(ADDR_CTRL, got);   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", got, e); end
        rd(ADDR_CMP, got);    e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL reset_cmp got=%h exp=%h", got, e); end
        rd(ADDR_PERIOD, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL reset_period got=%h exp=%h", got, e); end
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL reset_status got=%h exp=%h", got, e); end
        got = {31'd0, irq};   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL reset_irq got=%h exp=%h", got, e); end
    endtask

    task automatic test_one_shot();
        do_reset();
        wr(ADDR_CMP, 32'd5);
        wr(ADDR_CTRL, 32'hFFFF_FFFD);          // EN|IE, upper bits must not stick
        exp_q.push_back(32'd5);
        rd(ADDR_CTRL, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL os_ctrl_rb got=%h exp=%h", got, e); end
        bus.A = ADDR_CMP; bus.WD = 32'h123; bus.WE = 1'b0;
        tick();                                 // arms, write without strobe
        exp_q.push_back(32'd5);
        rd(ADDR_CMP, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL os_we0 got=%h exp=%h", got, e); end
        timer_val = 32'd4; tick();
        timer_val = 32'd5; tick();              // match sampled here
        exp_q.push_back(32'd9);                 // EXPIRED, PEND
        exp_q.push_back(32'd0);
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL os_status got=%h exp=%h", got, e); end
        got = {31'd0, irq};   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL os_irq_n1 got=%h exp=%h", got, e); end
        tick();
        exp_q.push_back(32'd1);
        got = {31'd0, irq};   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL os_irq_n2 got=%h exp=%h", got, e); end
        wr(ADDR_STATUS, 32'd1);
        timer_val = 32'd6; tick();
        timer_val = 32'd5; tick();              // ignored while EXPIRED
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd0);
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL os_no_repend got=%h exp=%h", got, e); end
        got = {31'd0, irq};   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL os_irq_clr got=%h exp=%h", got, e); end
        wr(ADDR_CMP, 32'd7);                    // re-arm from EXPIRED
        exp_q.push_back(32'd4);
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL os_rearm got=%h exp=%h", got, e); end
        wr(ADDR_CTRL, 32'd0);
        exp_q.push_back(32'd0);
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL os_disable got=%h exp=%h", got, e); end
    endtask

    task automatic test_first_sample();
        do_reset();
        wr(ADDR_CMP, 32'd0);
        wr(ADDR_CTRL, 32'd5);
        tick();
        tick();
        exp_q.push_back(32'd4);                 // ARMED, timer==CMP==0 but unchanged
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL fs_nomatch got=%h exp=%h", got, e); end
        timer_val = 32'd1; tick();
        timer_val = 32'd0; tick();
        exp_q.push_back(32'd9);
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL fs_match got=%h exp=%h", got, e); end
    endtask

    task automatic test_periodic_wrap();
        do_reset();
        wr(ADDR_CMP, 32'hFFFF_FFF0);
        wr(ADDR_PERIOD, 32'h20);
        wr(ADDR_CTRL, 32'd7);
        timer_val = 32'hFFFF_FFEF; tick();
        timer_val = 32'hFFFF_FFF0; tick();
        exp_q.push_back(32'h0000_0010);
        exp_q.push_back(32'd5);
        rd(ADDR_CMP, got);    e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL pw_cmp got=%h exp=%h", got, e); end
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL pw_status got=%h exp=%h", got, e); end
        tick();
        exp_q.push_back(32'd1);
        got = {31'd0, irq};   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL pw_irq got=%h exp=%h", got, e); end
    endtask

    task automatic test_overrun();
        do_reset();
        wr(ADDR_CMP, 32'd10);
        wr(ADDR_PERIOD, 32'd1);
        wr(ADDR_CTRL, 32'd7);
        timer_val = 32'd9;  tick();
        timer_val = 32'd10; tick();
        timer_val = 32'd11; tick();
        exp_q.push_back(32'd7);                 // ARMED, OVR, PEND
        exp_q.push_back(32'd1);
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL ov_status got=%h exp=%h", got, e); end
        got = {31'd0, irq};   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL ov_irq got=%h exp=%h", got, e); end
        wr(ADDR_STATUS, 32'd3);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd1);
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL ov_clear got=%h exp=%h", got, e); end
        got = {31'd0, irq};   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL ov_irq_n1 got=%h exp=%h", got, e); end
        tick();
        exp_q.push_back(32'd0);
        got = {31'd0, irq};   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL ov_irq_n2 got=%h exp=%h", got, e); end
    endtask

    task automatic test_collision();
        do_reset();
        wr(ADDR_CMP, 32'd20);
        wr(ADDR_CTRL, 32'd7);                   // periodic with PERIOD = 0
        timer_val = 32'd19; tick();
        bus.A = ADDR_STATUS; bus.WD = 32'd1; bus.WE = 1'b1; timer_val = 32'd20;
        tick();
        bus.WE = 1'b0;
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd20);
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL col_set_wins got=%h exp=%h", got, e); end
        rd(ADDR_CMP, got);    e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL col_period0 got=%h exp=%h", got, e); end
        wr(ADDR_STATUS, 32'd1);
        timer_val = 32'd21; tick();
        bus.A = ADDR_CMP; bus.WD = 32'h55; bus.WE = 1'b1; timer_val = 32'd20;
        tick();
        bus.WE = 1'b0;
        exp_q.push_back(32'd4);
        exp_q.push_back(32'h55);
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL col_cmp_wins got=%h exp=%h", got, e); end
        rd(ADDR_CMP, got);    e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL col_cmp_val got=%h exp=%h", got, e); end
    endtask

    // Runs after test_collision: ARMED, periodic, CMP = 0x55, PERIOD = 0.
    task automatic test_prescale_hold();
        timer_val = 32'h54; tick();
        timer_val = 32'h55;
        repeat (100) tick();
        exp_q.push_back(32'd5);                 // PEND once, no OVR
        exp_q.push_back(32'd1);
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL hold_status got=%h exp=%h", got, e); end
        got = {31'd0, irq};   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL hold_irq got=%h exp=%h", got, e); end
    endtask

    // Runs after test_prescale_hold: ARMED with PEND and irq high.
    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'hFFFF_FFFF);
        got = {31'd0, irq};   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL ar_irq got=%h exp=%h", got, e); end
        rd(ADDR_STATUS, got); e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL ar_status got=%h exp=%h", got, e); end
        rd(ADDR_CTRL, got);   e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL ar_ctrl got=%h exp=%h", got, e); end
        rd(ADDR_CMP, got);    e = exp_q.pop_front(); total++; if (got !== e) begin bad++; $display("FAIL ar_cmp got=%h exp=%h", got, e); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.A     = ADDR_CTRL;
        bus.WD    = '0;
        bus.WE    = 1'b0;
        timer_val = '0;
        rst_n     = 1'b0;
        test_reset();
        test_one_shot();
        test_first_sample();
        test_periodic_wrap();
        test_overrun();
        test_collision();
        test_prescale_hold();
        test_async_reset();
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_timer_irq_ctrl

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_CMP, default 32'hFFFF_FFFF, the compare register value after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port A, input, 2, register word select: 0 CTRL, 1 CMP, 2 PERIOD, 3 STATUS.
REQ-005 The block SHALL have port WD, input, 32, write data.
REQ-006 The block SHALL have port WE, input, 1, write strobe for the register selected by A.
REQ-007 The block SHALL have port RD, output, 32, combinational read data of the register selected by A.
REQ-008 The block SHALL have port timer_val, input, 32, current count of the free-running timer peripheral.
REQ-009 The block SHALL have port irq, output, 1, registered level interrupt to the core.

Function
REQ-010 CTRL SHALL hold EN (bit0), PERIODIC (bit1), IE (bit2); other bits SHALL read 0.
REQ-011 STATUS SHALL read PEND (bit0), OVR (bit1), state (bits 3:2); writing 1 to bit0/bit1 SHALL clear PEND/OVR; other bits are read-only 0.
REQ-012 The FSM SHALL have states IDLE (2'd0), ARMED (2'd1), EXPIRED (2'd2).
REQ-013 IDLE -> ARMED when EN is 1; any state -> IDLE in the cycle after a CTRL write with EN=0.
REQ-014 A match SHALL be declared when timer_val == CMP and timer_val differs from its value registered in the previous cycle (one match per timer step, regardless of timer prescale).
REQ-015 On a match in ARMED: PEND SHALL set at that clock edge; if PERIODIC, CMP SHALL become CMP + PERIOD modulo 2^32 and state stays ARMED; otherwise state -> EXPIRED.
REQ-016 EXPIRED SHALL leave only via a CMP write (-> ARMED, if EN) or EN cleared (-> IDLE).
REQ-017 A match while PEND is already 1 SHALL set OVR.
REQ-018 irq SHALL equal PEND & IE registered: match sampled in cycle N -> PEND high from cycle N+1 -> irq high from cycle N+2.
REQ-019 Set SHALL win over clear: a STATUS write-1-clear coinciding with a match leaves PEND (and OVR if applicable) set.
REQ-020 A CMP write in the same cycle as a match SHALL take priority: the match is suppressed and CMP takes WD.
REQ-021 Matches in IDLE or EXPIRED SHALL be ignored (no PEND, no OVR, no reload).
REQ-022 PERIOD = 0 in periodic mode SHALL leave CMP unchanged; repeated matches occur only when the timer wraps back to CMP.
REQ-023 Writes with WE=0 or to read-only bits SHALL have no effect.

Reset
REQ-024 While rst_n is 0: CTRL=0, CMP=RESET_CMP, PERIOD=0, PEND=0, OVR=0, state=IDLE, irq=0, previous-timer register=0.
REQ-025 Reset asserted mid-operation SHALL immediately force all of the above, independent of clk.
REQ-026 After reset release, the first timer_val sample SHALL NOT produce a match unless it differs from 0 and equals CMP.

Structure
REQ-027 Package timer_pkg SHALL hold register address constants, CTRL/STATUS bit indices, and FSM state encodings.
REQ-028 Match detection (previous-value register plus equality compare) SHALL be a single sub-module timer_cmp_match; everything else is in timer_irq_ctrl.

Verification
REQ-029 One-shot: CMP=5, CTRL=0b101; timer steps 4->5 -> PEND=1 one cycle later, irq=1 two cycles later, state=EXPIRED; timer 5->6->5 via WE -> no new PEND after clear.
REQ-030 Periodic wrap: CMP=32'hFFFF_FFF0, PERIOD=32'h20, CTRL=0b111; match -> CMP reads 32'h0000_0010, state stays ARMED.
REQ-031 Overrun: periodic, PERIOD=1, PEND left uncleared; two consecutive timer steps both match -> OVR=1; write STATUS=3 -> PEND=OVR=0, irq low two cycles later.
REQ-032 Collision: STATUS clear write in the match cycle -> PEND remains 1; CMP write in the match cycle -> PEND stays 0, CMP=WD.
REQ-033 Prescaled hold: timer_val held at CMP for 100 cycles -> exactly one match, PEND set once.
REQ-034 Reset mid-ARMED with PEND=1 -> irq, PEND, state, CTRL all 0 without a clock edge; CMP reads 32'hFFFF_FFFF.
